// File: rtl/blackjack_round_fsm.sv
// blackjack_round_fsm: blackjack round controller (deal, player hit/stand, dealer draw, tallies); BJ_SOFT_ACE_EN enables soft aces
module blackjack_round_fsm #(
  parameter int HAND_W       = 6,
  parameter int TARGET       = 21,
  parameter int DEALER_STAND = 17,
  parameter int CARD_MAX     = 10,
  parameter int SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               new_round,
  input  logic               hit,
  input  logic               stand,
  input  logic [3:0]         card_in,
  output logic [HAND_W-1:0]  phand,
  output logic [HAND_W-1:0]  dhand,
  output logic [3:0]         last_card,
  output logic               deal_pulse,
  output logic [2:0]         state,
  output logic [1:0]         result,
  output logic [SCORE_W-1:0] p_wins,
  output logic [SCORE_W-1:0] d_wins
);
  typedef enum logic [2:0] {IDLE = 3'd0, DEAL = 3'd1, PLAYER = 3'd2, DEALER = 3'd3, RESULT = 3'd4} state_t;
  localparam logic [HAND_W-1:0] TGT = HAND_W'(TARGET);
  localparam logic [HAND_W-1:0] STD = HAND_W'(DEALER_STAND);
  state_t state_q, state_d;
  logic new_round_q, hit_q, stand_q;
  logic [2:0] cnt_q, cnt_d;
  logic [HAND_W-1:0] phard_q, phard_d, dhard_q, dhard_d, pe, de;
  logic [3:0] last_q, last_d, card;
  logic pulse_q, pulse_d;
  logic [1:0] res_q, res_d;
  logic [SCORE_W-1:0] pw_q, pw_d, dw_q, dw_d;
  logic nr_rise, hit_rise, stand_rise;
  logic clear, p_deal, d_deal, win, lose, push;
  function automatic logic [HAND_W-1:0] sat_add(input logic [HAND_W-1:0] h, input logic [3:0] c);
    logic [HAND_W:0] s;
    s = {1'b0, h} + (HAND_W+1)'(c);
    return s[HAND_W] ? '1 : s[HAND_W-1:0];
  endfunction
  assign nr_rise    = new_round & ~new_round_q;
  assign hit_rise   = hit & ~hit_q;
  assign stand_rise = stand & ~stand_q;
  assign card = card_in == 4'd0 ? 4'd1 : card_in > 4'(CARD_MAX) ? 4'(CARD_MAX) : card_in;
`ifdef BJ_SOFT_ACE_EN
  logic pace_q, pace_d, dace_q, dace_d;
  function automatic logic [HAND_W-1:0] eff(input logic [HAND_W-1:0] h, input logic a);
    logic [HAND_W:0] s;
    s = {1'b0, h} + (HAND_W+1)'(10);
    return (a && s <= (HAND_W+1)'(TARGET)) ? s[HAND_W-1:0] : h;
  endfunction
  assign pace_d = clear ? 1'b0 : pace_q | (p_deal & card == 4'd1);
  assign dace_d = clear ? 1'b0 : dace_q | (d_deal & card == 4'd1);
  assign pe = eff(phard_q, pace_q);
  assign de = eff(dhard_q, dace_q);
  // ace flags, one per hand
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pace_q <= 1'b0;
      dace_q <= 1'b0;
    end else begin
      pace_q <= pace_d;
      dace_q <= dace_d;
    end
`else
  assign pe = phard_q;
  assign de = dhard_q;
`endif
  // round sequencing: which hand draws this cycle and how the round ends
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clear   = 1'b0;
    p_deal  = 1'b0;
    d_deal  = 1'b0;
    win     = 1'b0;
    lose    = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: if (nr_rise) begin
        clear   = 1'b1;
        cnt_d   = 3'd0;
        state_d = DEAL;
      end
      DEAL: if (cnt_q == 3'd4) begin
        win     = pe == TGT;
        lose    = pe > TGT;
        state_d = (pe >= TGT) ? RESULT : PLAYER;
      end else begin
        p_deal = ~cnt_q[0];
        d_deal = cnt_q[0];
        cnt_d  = cnt_q + 3'd1;
      end
      PLAYER: begin
        win     = pe == TGT;
        lose    = pe > TGT;
        p_deal  = pe < TGT && hit_rise;
        state_d = pe >= TGT ? RESULT : (!hit_rise && stand_rise) ? DEALER : PLAYER;
      end
      DEALER: if (de < STD) d_deal = 1'b1;
      else begin
        win     = de > TGT || pe > de;
        lose    = de <= TGT && pe < de;
        push    = de <= TGT && pe == de;
        state_d = RESULT;
      end
      RESULT: state_d = nr_rise ? IDLE : RESULT;
      default: state_d = IDLE;
    endcase
  end
  assign phard_d = clear ? '0 : p_deal ? sat_add(phard_q, card) : phard_q;
  assign dhard_d = clear ? '0 : d_deal ? sat_add(dhard_q, card) : dhard_q;
  assign pulse_d = p_deal | d_deal;
  assign last_d  = pulse_d ? card : last_q;
  assign res_d   = clear ? 2'd0 : win ? 2'd1 : lose ? 2'd2 : push ? 2'd3 : res_q;
  assign pw_d    = (win && pw_q != '1) ? pw_q + SCORE_W'(1) : pw_q;
  assign dw_d    = (lose && dw_q != '1) ? dw_q + SCORE_W'(1) : dw_q;
  // state, hands, edge detectors and tallies
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      new_round_q <= 1'b0;
      hit_q       <= 1'b0;
      stand_q     <= 1'b0;
      phard_q     <= '0;
      dhard_q     <= '0;
      last_q      <= '0;
      pulse_q     <= 1'b0;
      res_q       <= '0;
      pw_q        <= '0;
      dw_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      new_round_q <= new_round;
      hit_q       <= hit;
      stand_q     <= stand;
      phard_q     <= phard_d;
      dhard_q     <= dhard_d;
      last_q      <= last_d;
      pulse_q     <= pulse_d;
      res_q       <= res_d;
      pw_q        <= pw_d;
      dw_q        <= dw_d;
    end
  assign phand      = pe;
  assign dhand      = de;
  assign last_card  = last_q;
  assign deal_pulse = pulse_q;
  assign state      = state_q;
  assign result     = res_q;
  assign p_wins     = pw_q;
  assign d_wins     = dw_q;
endmodule
